serial_frame_rx: RTL and testbench

- Receiving end of the byte-serial link driven by the team's parallel-in/serial-out shifters.
- Detects a start bit, shifts in WIDTH data bits MSB-first, and checks the stop bit.
- Presents the word on a parallel output with a one-cycle valid strobe.
- Sits between the serial line and byte-oriented logic. Bit timing comes from an external bit-rate strobe; there is no oversampling.

---
 rtl/serial_frame_rx.sv | 147 ++++++++++++++
 tb/tb_serial_frame_rx.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, WIDTH data bits (MSB- or LSB-first), stop bit, strobed by bit_en.
// Optional even-parity bit between data and stop when PARITY_FRAME_EN is defined (adds parity_err).
module serial_frame_rx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_en,
  input  logic             serial,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             frame_err,
`ifdef PARITY_FRAME_EN
  output logic             parity_err,
`endif
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

`ifdef PARITY_FRAME_EN
  typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP, BREAK} state_t;
`else
  typedef enum logic [1:0] {IDLE, DATA, STOP, BREAK} state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             frame_err_q, frame_err_d;
  logic             busy_q, busy_d;
`ifdef PARITY_FRAME_EN
  logic             par_q, par_d;
  logic             parity_err_q, parity_err_d;
`endif

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] s, input logic b);
    if (MSB_FIRST) return {s[WIDTH-2:0], b};
    else           return {b, s[WIDTH-1:1]};
  endfunction

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    dout_d      = dout_q;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;
`ifdef PARITY_FRAME_EN
    par_d        = par_q;
    parity_err_d = 1'b0;
`endif
    if (bit_en) begin
      case (state_q)
        IDLE: begin
          if (!serial) begin
            cnt_d   = '0;
            state_d = DATA;
          end
        end
        DATA: begin
          shreg_d = shift_in(shreg_q, serial);
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LAST_BIT) begin
`ifdef PARITY_FRAME_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
`ifdef PARITY_FRAME_EN
        PARITY: begin
          par_d   = serial;
          state_d = STOP;
        end
`endif
        STOP: begin
          if (serial) begin
`ifdef PARITY_FRAME_EN
            // Even parity: data bits plus parity bit must XOR to zero.
            if ((^shreg_q) ^ par_q) begin
              parity_err_d = 1'b1;
            end else begin
              dout_d  = shreg_q;
              valid_d = 1'b1;
            end
`else
            dout_d  = shreg_q;
            valid_d = 1'b1;
`endif
            state_d = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = BREAK;
          end
        end
        BREAK: begin
          if (serial) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      cnt_q        <= '0;
      dout_q       <= '0;
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
`ifdef PARITY_FRAME_EN
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      dout_q       <= dout_d;
      valid_q      <= valid_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
`ifdef PARITY_FRAME_EN
      par_q        <= par_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign dout      = dout_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;
`ifdef PARITY_FRAME_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_serial_frame_rx.sv
// Scoreboard bench for serial_frame_rx: an MSB-first and an LSB-first instance share one serial line.
module tb_serial_frame_rx;

  localparam int WIDTH = 8;
`ifdef PARITY_FRAME_EN
  localparam int FRAME_BITS = WIDTH + 3;
`else
  localparam int FRAME_BITS = WIDTH + 2;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             bit_en;
  logic             serial;
  logic [WIDTH-1:0] dout_m, dout_l;
  logic             valid_m, valid_l, ferr_m, ferr_l, busy_m, busy_l;
`ifdef PARITY_FRAME_EN
  logic             perr_m, perr_l;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ferr_cnt_m = 0, ferr_cnt_l = 0, exp_ferr = 0;
  logic valid_m_prev = 1'b0, valid_l_prev = 1'b0;
  logic [WIDTH-1:0] q_m[$];
  logic [WIDTH-1:0] q_l[$];
  int stamps[$];

  serial_frame_rx #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .bit_en(bit_en), .serial(serial),
    .dout(dout_m), .valid(valid_m), .frame_err(ferr_m),
`ifdef PARITY_FRAME_EN
    .parity_err(perr_m),
`endif
    .busy(busy_m)
  );

  serial_frame_rx #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .bit_en(bit_en), .serial(serial),
    .dout(dout_l), .valid(valid_l), .frame_err(ferr_l),
`ifdef PARITY_FRAME_EN
    .parity_err(perr_l),
`endif
    .busy(busy_l)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [WIDTH-1:0] rev(input logic [WIDTH-1:0] w);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) r[i] = w[WIDTH-1-i];
    return r;
  endfunction

  // Scoreboard side: pop and compare whenever a receiver reports a word.
  always @(negedge clk) begin
    if (!rst) begin
      if (valid_m) begin
        check("valid_m_1cyc", {31'b0, valid_m_prev}, 32'd0);
        stamps.push_back(cyc);
        if (q_m.size() == 0) check("valid_m_unexpected", 32'd1, 32'd0);
        else                 check("dout_m", dout_m, q_m.pop_front());
      end
      if (valid_l) begin
        check("valid_l_1cyc", {31'b0, valid_l_prev}, 32'd0);
        if (q_l.size() == 0) check("valid_l_unexpected", 32'd1, 32'd0);
        else                 check("dout_l", dout_l, q_l.pop_front());
      end
      if (ferr_m) ferr_cnt_m++;
      if (ferr_l) ferr_cnt_l++;
    end
    valid_m_prev = valid_m;
    valid_l_prev = valid_l;
  end

  // Entered and left at posedge+1; serial carries junk (~b) during the gap cycles.
  task automatic send_bit(input logic b, input int gap);
    bit_en = 1'b0;
    serial = ~b;
    repeat (gap - 1) begin
      @(posedge clk); #1;
    end
    bit_en = 1'b1;
    serial = b;
    @(posedge clk); #1;
    bit_en = 1'b0;
    serial = 1'b1;
  endtask

  task automatic send_frame(input logic [WIDTH-1:0] w, input logic stop_b,
                            input logic par_good, input int gap);
    logic good;
    good = stop_b;
`ifdef PARITY_FRAME_EN
    good = stop_b & par_good;
`endif
    if (good) begin
      q_m.push_back(w);
      q_l.push_back(rev(w));
    end
    if (!stop_b) exp_ferr++;
    send_bit(1'b0, gap);
    for (int i = WIDTH - 1; i >= 0; i--) send_bit(w[i], gap);
`ifdef PARITY_FRAME_EN
    send_bit((^w) ^ ~par_good, gap);
`endif
    send_bit(stop_b, gap);
    check("valid_latency", {31'b0, valid_m}, {31'b0, good});
    check("ferr_latency", {31'b0, ferr_m}, {31'b0, ~stop_b});
`ifdef PARITY_FRAME_EN
    check("perr_latency", {31'b0, perr_m}, {31'b0, stop_b & ~par_good});
    check("perr_l_latency", {31'b0, perr_l}, {31'b0, stop_b & ~par_good});
`endif
  endtask

  initial begin
    logic [WIDTH-1:0] w;
    int gap;
    rst = 1'b1; bit_en = 1'b0; serial = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dout", dout_m, 0);
    check("rst_valid", {31'b0, valid_m}, 0);
    check("rst_ferr", {31'b0, ferr_m}, 0);
    check("rst_busy", {31'b0, busy_m}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Clean 0xA5, strobe every cycle
    send_frame(8'hA5, 1'b1, 1'b1, 1);
    send_bit(1'b1, 1);
    check("clean_valid_gone", {31'b0, valid_m}, 0);
    check("clean_busy_low", {31'b0, busy_m}, 0);

    // Sparse strobe every 4th cycle; LSB instance sees 1,0,1,0,0,1,0,1 as 0xA5
    send_frame(8'hA5, 1'b1, 1'b1, 4);
    check("sparse_dout_l", dout_l, 8'hA5);
    check("sparse_busy_l", {31'b0, busy_l}, 0);

    // Framing error, held-low line, return to idle
    send_frame(8'hFF, 1'b0, 1'b1, 1);
    check("ferr_keep_dout_m", dout_m, 8'hA5);
    check("ferr_keep_dout_l", dout_l, 8'hA5);
    for (int i = 0; i < 3; i++) begin
      send_bit(1'b0, 1);
      check("break_busy", {31'b0, busy_m}, 1);
      check("break_no_ferr", {31'b0, ferr_m}, 0);
    end
    send_bit(1'b1, 1);
    check("break_exit_idle", {31'b0, busy_m}, 0);
    send_bit(1'b1, 1);
    check("break_still_idle", {31'b0, busy_m}, 0);

    // Reset after 4 data bits
    send_bit(1'b0, 1);
    for (int i = 0; i < 4; i++) send_bit(i[0], 1);
    check("midframe_busy", {31'b0, busy_m}, 1);
    rst = 1'b1;
    #1;
    check("arst_dout_m", dout_m, 0);
    check("arst_dout_l", dout_l, 0);
    check("arst_busy", {31'b0, busy_m}, 0);
    check("arst_valid", {31'b0, valid_m}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    send_frame(8'h3C, 1'b1, 1'b1, 1);
    send_bit(1'b1, 1);

    // Back-to-back, no idle bit
    stamps.delete();
    send_frame(8'h12, 1'b1, 1'b1, 1);
    send_frame(8'h34, 1'b1, 1'b1, 1);
    send_bit(1'b1, 1);
    check("b2b_count", stamps.size(), 2);
    if (stamps.size() == 2) check("b2b_spacing", stamps[1] - stamps[0], FRAME_BITS);
    check("b2b_last_dout", dout_m, 8'h34);

    // Random words with random strobe spacing
    for (int k = 0; k < 6; k++) begin
      w   = WIDTH'($urandom);
      gap = int'($urandom_range(1, 3));
      send_frame(w, 1'b1, 1'b1, gap);
    end

`ifdef PARITY_FRAME_EN
    send_bit(1'b1, 1);
    send_frame(8'h07, 1'b1, 1'b1, 1);
    check("par_ok_dout", dout_m, 8'h07);
    send_frame(8'h07, 1'b1, 1'b0, 1);
    check("par_bad_dout", dout_m, 8'h07);
    send_frame(8'h07, 1'b0, 1'b1, 1);
    send_bit(1'b1, 1);
`endif

    repeat (4) send_bit(1'b1, 1);
    check("sb_m_empty", q_m.size(), 0);
    check("sb_l_empty", q_l.size(), 0);
    check("ferr_count_m", ferr_cnt_m, exp_ferr);
    check("ferr_count_l", ferr_cnt_l, exp_ferr);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
